// File: rtl/servo_pwm_dzj.sv
// servo_pwm_dzj: BCD angle word to hobby-servo PWM.
// New pulse widths are applied only at a period boundary.
module servo_pwm_dzj #(
    parameter int PERIOD_CYC    = 480000,
    parameter int PULSE_MIN_CYC = 12000,
    parameter int STEP_CYC      = 267,
    parameter int ANGLE_MAX     = 180
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] jiaodu,
    output logic       pwm_out,
    output logic [8:0] angle_bin,
    output logic       busy,
    output logic       upd,
    output logic       fmt_err,
    output logic       clamp
);

    localparam logic [19:0] PER_LAST = 20'(PERIOD_CYC - 1);
    localparam logic [19:0] MIN_W    = 20'(PULSE_MIN_CYC);
    localparam logic [19:0] STEP_W   = 20'(STEP_CYC);
    localparam logic [8:0]  AMAX_W   = 9'(ANGLE_MAX);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        CLAMP,
        MULT,
        PEND
    } state_t;

    state_t      state;
    logic [19:0] cnt;
    logic [19:0] pw_active;
    logic [19:0] acc;
    logic [9:0]  jiaodu_q;
    logic [8:0]  ang;
    logic [3:0]  i;
    logic        bcd_bad;
    logic [8:0]  ang_bcd;
    logic        period_end;

    assign bcd_bad    = (jiaodu_q[7:4] > 4'd9) || (jiaodu_q[3:0] > 4'd9);
    assign ang_bcd    = 9'(jiaodu_q[9:8]) * 9'd100
                      + 9'(jiaodu_q[7:4]) * 9'd10
                      + 9'(jiaodu_q[3:0]);
    assign period_end = (cnt == PER_LAST);

    // Free-running period counter and registered PWM compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            pwm_out <= 1'b0;
        end else begin
            cnt     <= period_end ? 20'd0 : cnt + 20'd1;
            pwm_out <= (cnt < pw_active);
        end
    end

    // Capture, convert, clamp, shift-add multiply, then load at boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            jiaodu_q  <= '0;
            ang       <= '0;
            acc       <= '0;
            i         <= '0;
            pw_active <= MIN_W;
            angle_bin <= '0;
            busy      <= 1'b0;
            upd       <= 1'b0;
            fmt_err   <= 1'b0;
            clamp     <= 1'b0;
        end else begin
            upd     <= 1'b0;
            fmt_err <= 1'b0;
            clamp   <= 1'b0;
            case (state)
                IDLE: begin
                    if (jiaodu != jiaodu_q) begin
                        jiaodu_q <= jiaodu;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    if (bcd_bad) begin
                        fmt_err <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        ang   <= ang_bcd;
                        state <= CLAMP;
                    end
                end
                CLAMP: begin
                    if (ang > AMAX_W) begin
                        ang   <= AMAX_W;
                        clamp <= 1'b1;
                    end
                    acc   <= MIN_W;
                    i     <= '0;
                    state <= MULT;
                end
                MULT: begin
                    acc <= acc + (ang[i] ? (STEP_W << i) : 20'd0);
                    if (i == 4'd8) begin
                        state <= PEND;
                    end else begin
                        i <= i + 4'd1;
                    end
                end
                PEND: begin
                    if (period_end) begin
                        pw_active <= acc;
                        angle_bin <= ang;
                        upd       <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servo_pwm_dzj.sv
// tb_servo_pwm_dzj: directed scenarios for servo_pwm_dzj
// using a short period so each scenario spans a few periods.
module tb_servo_pwm_dzj;

    localparam int P    = 2000;
    localparam int PMIN = 100;
    localparam int STEP = 5;
    localparam int AMAX = 180;

    logic       clk;
    logic       rst_n;
    logic [9:0] jiaodu;
    logic       pwm_out;
    logic [8:0] angle_bin;
    logic       busy;
    logic       upd;
    logic       fmt_err;
    logic       clamp;

    int n_checks = 0;
    int n_fail   = 0;

    int hi_cnt = 0;
    int lo_cnt = 0;
    int last_hi = 0;
    int last_lo = 0;
    int npulse = 0;
    int nupd = 0;
    int nclamp = 0;
    int nbusy = 0;

    servo_pwm_dzj #(
        .PERIOD_CYC   (P),
        .PULSE_MIN_CYC(PMIN),
        .STEP_CYC     (STEP),
        .ANGLE_MAX    (AMAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .jiaodu   (jiaodu),
        .pwm_out  (pwm_out),
        .angle_bin(angle_bin),
        .busy     (busy),
        .upd      (upd),
        .fmt_err  (fmt_err),
        .clamp    (clamp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse/gap length and event monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hi_cnt = 0;
            lo_cnt = 0;
        end else begin
            if (pwm_out) begin
                if (lo_cnt != 0) begin
                    last_lo = lo_cnt;
                    lo_cnt  = 0;
                end
                hi_cnt++;
            end else begin
                if (hi_cnt != 0) begin
                    last_hi = hi_cnt;
                    npulse++;
                    hi_cnt = 0;
                end
                lo_cnt++;
            end
            if (upd) nupd++;
            if (clamp) nclamp++;
            if (busy) nbusy++;
        end
    end

    task automatic wait_pulses(input int n, output bit ok);
        int tgt;
        tgt = npulse + n;
        for (int k = 0; k < 4 * P * n && npulse < tgt; k++) begin
            @(negedge clk);
            #1;
        end
        ok = (npulse >= tgt);
    endtask

    task automatic wait_upd(output bit ok);
        int u0;
        u0 = nupd;
        for (int k = 0; k < 3 * P && nupd == u0; k++) begin
            @(negedge clk);
            #1;
        end
        ok = (nupd != u0);
    endtask

    task automatic wait_idle(output bit ok);
        for (int k = 0; k < 3 * P && busy; k++) begin
            @(negedge clk);
        end
        #1;
        ok = !busy;
    endtask

    task automatic test_reset();
        bit ok;
        rst_n  = 1'b0;
        jiaodu = 10'h000;
        repeat (3) @(negedge clk);
        n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL rst_pwm got %b exp 0", pwm_out); end
        n_checks++; if (angle_bin !== 9'd0) begin n_fail++; $display("FAIL rst_angle got %0d exp 0", angle_bin); end
        n_checks++; if ({busy, upd, fmt_err, clamp} !== 4'b0) begin n_fail++; $display("FAIL rst_flags got %b exp 0000", {busy, upd, fmt_err, clamp}); end
        rst_n = 1'b1;
        nbusy = 0;
        wait_pulses(2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_timeout got none exp 2 pulses"); end
        n_checks++; if (last_hi !== PMIN) begin n_fail++; $display("FAIL rst_width got %0d exp %0d", last_hi, PMIN); end
        n_checks++; if (last_lo !== P - PMIN) begin n_fail++; $display("FAIL rst_gap got %0d exp %0d", last_lo, P - PMIN); end
        n_checks++; if (nbusy !== 0) begin n_fail++; $display("FAIL rst_busy got %0d exp 0", nbusy); end
    endtask

    task automatic test_angle90();
        bit ok;
        int b;
        int u0;
        u0 = nupd;
        @(negedge clk);
        jiaodu = 10'h090;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL a90_busy got %b exp 1", busy); end
        b = 0;
        for (int k = 0; k < 3 * P && busy; k++) begin
            @(negedge clk);
            b++;
        end
        #1;
        n_checks++; if (b < 12) begin n_fail++; $display("FAIL a90_busylen got %0d exp >=12", b); end
        n_checks++; if (nupd !== u0 + 1) begin n_fail++; $display("FAIL a90_upd got %0d exp %0d", nupd, u0 + 1); end
        n_checks++; if (angle_bin !== 9'd90) begin n_fail++; $display("FAIL a90_angle got %0d exp 90", angle_bin); end
        wait_pulses(1, ok);
        n_checks++; if (last_hi !== 550) begin n_fail++; $display("FAIL a90_width got %0d exp 550", last_hi); end
    endtask

    task automatic test_clamp();
        bit ok;
        int c0;
        c0 = nclamp;
        @(negedge clk);
        jiaodu = 10'h250;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (clamp !== 1'b0) begin n_fail++; $display("FAIL clamp_early got %b exp 0", clamp); end
        @(negedge clk);
        n_checks++; if (clamp !== 1'b1) begin n_fail++; $display("FAIL clamp_pulse got %b exp 1", clamp); end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL clamp_timeout got busy exp idle"); end
        n_checks++; if (angle_bin !== 9'd180) begin n_fail++; $display("FAIL clamp_angle got %0d exp 180", angle_bin); end
        n_checks++; if (nclamp !== c0 + 1) begin n_fail++; $display("FAIL clamp_count got %0d exp %0d", nclamp, c0 + 1); end
        wait_pulses(1, ok);
        n_checks++; if (last_hi !== 1000) begin n_fail++; $display("FAIL clamp_width got %0d exp 1000", last_hi); end
    endtask

    task automatic test_fmt_err();
        bit ok;
        int u0;
        u0 = nupd;
        @(negedge clk);
        jiaodu = 10'h0A5;
        @(negedge clk);
        n_checks++; if (fmt_err !== 1'b0) begin n_fail++; $display("FAIL fmt_early got %b exp 0", fmt_err); end
        @(negedge clk);
        n_checks++; if (fmt_err !== 1'b1) begin n_fail++; $display("FAIL fmt_pulse got %b exp 1", fmt_err); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fmt_busy got %b exp 0", busy); end
        wait_pulses(2, ok);
        n_checks++; if (last_hi !== 1000) begin n_fail++; $display("FAIL fmt_width got %0d exp 1000", last_hi); end
        n_checks++; if (nupd !== u0) begin n_fail++; $display("FAIL fmt_upd got %0d exp %0d", nupd, u0); end
        n_checks++; if (angle_bin !== 9'd180) begin n_fail++; $display("FAIL fmt_angle got %0d exp 180", angle_bin); end
    endtask

    task automatic test_mid_period();
        bit ok;
        int u0;
        for (int k = 0; k < 2 * P && !pwm_out; k++) @(negedge clk);
        repeat (500) @(negedge clk);
        u0 = nupd;
        jiaodu = 10'h045;
        wait_pulses(1, ok);
        n_checks++; if (last_hi !== 1000) begin n_fail++; $display("FAIL mid_oldwidth got %0d exp 1000", last_hi); end
        wait_pulses(1, ok);
        n_checks++; if (last_hi !== 325) begin n_fail++; $display("FAIL mid_newwidth got %0d exp 325", last_hi); end
        n_checks++; if (angle_bin !== 9'd45) begin n_fail++; $display("FAIL mid_angle got %0d exp 45", angle_bin); end
        n_checks++; if (nupd !== u0 + 1) begin n_fail++; $display("FAIL mid_upd got %0d exp %0d", nupd, u0 + 1); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int u0;
        u0 = nupd;
        @(negedge clk);
        jiaodu = 10'h030;
        repeat (5) @(negedge clk);
        jiaodu = 10'h120;
        wait_upd(ok);
        n_checks++; if (angle_bin !== 9'd30) begin n_fail++; $display("FAIL b2b_angle1 got %0d exp 30", angle_bin); end
        wait_pulses(1, ok);
        n_checks++; if (last_hi !== 250) begin n_fail++; $display("FAIL b2b_width1 got %0d exp 250", last_hi); end
        wait_upd(ok);
        n_checks++; if (angle_bin !== 9'd120) begin n_fail++; $display("FAIL b2b_angle2 got %0d exp 120", angle_bin); end
        wait_pulses(1, ok);
        n_checks++; if (last_hi !== 700) begin n_fail++; $display("FAIL b2b_width2 got %0d exp 700", last_hi); end
        n_checks++; if (nupd !== u0 + 2) begin n_fail++; $display("FAIL b2b_upd got %0d exp %0d", nupd, u0 + 2); end
    endtask

    task automatic test_reset_pend();
        bit ok;
        for (int k = 0; k < 2 * P && !pwm_out; k++) @(negedge clk);
        repeat (20) @(negedge clk);
        jiaodu = 10'h090;
        repeat (15) @(negedge clk);
        n_checks++; if ({busy, pwm_out} !== 2'b11) begin n_fail++; $display("FAIL rp_pre got %b exp 11", {busy, pwm_out}); end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL rp_pwm got %b exp 0", pwm_out); end
        n_checks++; if (angle_bin !== 9'd0) begin n_fail++; $display("FAIL rp_angle got %0d exp 0", angle_bin); end
        n_checks++; if ({busy, upd, fmt_err, clamp} !== 4'b0) begin n_fail++; $display("FAIL rp_flags got %b exp 0000", {busy, upd, fmt_err, clamp}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_pulses(1, ok);
        n_checks++; if (last_hi !== PMIN) begin n_fail++; $display("FAIL rp_width1 got %0d exp %0d", last_hi, PMIN); end
        wait_upd(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rp_timeout got no upd exp upd"); end
        n_checks++; if (angle_bin !== 9'd90) begin n_fail++; $display("FAIL rp_angle2 got %0d exp 90", angle_bin); end
        wait_pulses(1, ok);
        n_checks++; if (last_hi !== 550) begin n_fail++; $display("FAIL rp_width2 got %0d exp 550", last_hi); end
    endtask

    initial begin
        rst_n  = 1'b0;
        jiaodu = 10'h000;
        test_reset();
        test_angle90();
        test_clamp();
        test_fmt_err();
        test_mid_period();
        test_back_to_back();
        test_reset_pend();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
